// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and fetch-unit types.
// Opcodes, pc_src2 steering encodings and the fetch FSM state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    // jr is an R-type instruction; this is its func field value
    localparam logic [5:0] OP_JR    = 6'h08;

    localparam logic [1:0] PCS_SEQ      = 2'b00;
    localparam logic [1:0] PCS_JUMP     = 2'b01;
    localparam logic [1:0] PCS_JR       = 2'b10;
    localparam logic [1:0] PCS_JUMP_ALT = 2'b11;

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump register, then jump, then taken branch, else sequential.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] jump_index,
    input  logic        pc_src,
    input  logic [1:0]  pc_src2,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc,
    output logic        jr_misaligned
);

    logic [31:0] branch_off;

    // Low 16 bits of the jump index field double as the branch immediate
    assign branch_off = {{14{jump_index[15]}}, jump_index[15:0], 2'b00};

    always_comb begin
        next_pc       = pc_plus4;
        jr_misaligned = 1'b0;
        unique case (pc_src2)
            PCS_JR: begin
                next_pc       = {jr_target[31:2], 2'b00};
                jr_misaligned = |jr_target[1:0];
            end
            PCS_JUMP, PCS_JUMP_ALT: next_pc = {pc_plus4[31:28], jump_index, 2'b00};
            default: begin
                if (pc_src) next_pc = pc_plus4 + branch_off;
            end
        endcase
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request at a time
// and holds each fetched word for the decoder until it is accepted.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr,
    output logic [5:0]         opcode,
    output logic [5:0]         func,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    input  logic               pc_src,
    input  logic [1:0]         pc_src2,
    input  logic [31:0]        jr_target,
    output logic               align_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, instr_q, next_pc;
    logic         align_err_q, jr_misaligned, accept, capture, req_valid;

    assign accept  = (state_q == StHold) & instr_ready;
    assign capture = (state_q == StWait) & imem.imem_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StReq;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq:   if (imem.imem_req_ready) state_d = StWait;
            StWait:  if (imem.imem_rsp_valid) state_d = StHold;
            StHold:  if (instr_ready)         state_d = StReq;
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        req_valid   = (state_q == StReq);
        instr_valid = (state_q == StHold);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            align_err_q <= 1'b0;
        end else begin
            if (capture) instr_q <= imem.imem_rsp_data;
            if (accept) begin
                pc_q <= next_pc;
                if (jr_misaligned) align_err_q <= 1'b1;
            end
        end
    end

    next_pc_calc u_next_pc_calc (
        .pc_plus4      (pc_plus4),
        .jump_index    (instr_q[25:0]),
        .pc_src        (pc_src),
        .pc_src2       (pc_src2),
        .jr_target     (jr_target),
        .next_pc       (next_pc),
        .jr_misaligned (jr_misaligned)
    );

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_req_addr  = {pc_q[31:2], 2'b00};
    assign instr               = instr_q;
    assign opcode              = instr_q[31:26];
    assign func                = instr_q[5:0];
    assign pc                  = pc_q;
    assign pc_plus4            = pc_q + 32'd4;
    assign align_err           = align_err_q;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential instruction-fetch front end that supplies instruction words to the opcode/function decoder and consumes that decoder's program-counter steering outputs (`pc_src`, `pc_src2`) to form the next fetch address. It owns the PC, issues one outstanding request at a time to instruction memory over a valid/ready request and valid response interface, and presents each fetched word downstream with a valid/ready handshake. It sits between instruction memory and the control/datapath, replacing the bare PC register of the single-cycle datapath when memory latency is variable.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `imem_req_valid`  out  1  Fetch request valid.
- `imem_req_ready`  in  1  Memory accepts the request.
- `imem_req_addr`  out  32  Byte address of the fetch; bits [1:0] are always 0.
- `imem_rsp_valid`  in  1  Response word valid (one per accepted request).
- `imem_rsp_data`  in  32  Instruction word.
- `instr_valid`  out  1  Instruction presented downstream.
- `instr_ready`  in  1  Downstream consumes the instruction this cycle.
- `instr`  out  32  Held instruction word.
- `opcode`  out  6  `instr[31:26]`.
- `func`  out  6  `instr[5:0]`.
- `pc`  out  32  Address of the held instruction.
- `pc_plus4`  out  32  `pc + 4`, used as the link value for jal.
- `pc_src`  in  1  Branch taken (branch & zero); sampled on accept.
- `pc_src2`  in  2  00 sequential/branch, 01 jump (j/jal), 10 jump register, 11 treated as 01.
- `jr_target`  in  32  Register value for jump register.
- `align_err`  out  1  Sticky; set when a jr target has nonzero bits [1:0].

## Operation
- FSM states: REQ, WAIT, HOLD.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=`pc`. On `imem_req_ready`, go to WAIT.
- WAIT: `imem_req_valid`=0. On `imem_rsp_valid`, capture `imem_rsp_data` into `instr` and go to HOLD.
- HOLD: `instr_valid`=1, with `instr`, `opcode`, `func`, `pc` and `pc_plus4` stable. When `instr_valid & instr_ready`, load `pc` with the next PC and go to REQ.
- Next-PC priority, evaluated at accept:
  - `pc_src2`=10: `{jr_target[31:2],2'b00}`. If `jr_target[1:0]`≠0, set `align_err`.
  - `pc_src2`=01 or 11: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - Else if `pc_src`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Else: `pc_plus4`.
- All address arithmetic is modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal and silent.
- `pc_src`, `pc_src2` and `jr_target` are ignored outside the accept cycle.
- A `imem_rsp_valid` arriving outside WAIT is ignored.
- `align_err` clears only on reset.

## Timing
- Reset values: state=REQ, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `align_err`=0. `imem_req_valid` is 1 from the first cycle after reset release.
- Reset asserted mid-operation aborts immediately. Any in-flight response is dropped because the FSM restarts in REQ. Memory must discard its outstanding request on the same reset.
- Minimum instruction period is 3 cycles: request accepted in cycle N, response in N+1, `instr_valid` in N+2, accept in N+2, new request in N+3.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0.
- `instr` is stable while `instr_valid`=1 and `instr_ready`=0.
- Only one request is outstanding at a time; no request is issued while in WAIT or HOLD.
- Decoder outputs are combinational from `instr`, so they are valid in the same cycle as `instr_valid`.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_SLTI`, `OP_J`, `OP_JAL`, `OP_JR`);
  - `pc_src2` encodings (`PCS_SEQ`=00, `PCS_JUMP`=01, `PCS_JR`=10);
  - FSM state enum.
- One natural sub-module: `next_pc_calc`, purely combinational, implementing the next-PC priority above. FSM and registers stay in the top module.

## Test plan
- Reset with `RESET_PC`=32'h100, memory always ready, 1-cycle response, `instr_ready`=1, `pc_src`=0, `pc_src2`=00 -> requests to 0x100, 0x104, 0x108; one `instr_valid` pulse every 3 cycles.
- Beq at pc 0x200 with `instr[15:0]`=16'hFFFE and `pc_src`=1 -> next request address 0x1FC. Same case with `pc_src`=0 -> next request address 0x204.
- Jal at pc 0x8000_0010 with `instr[25:0]`=26'h0000_040 and `pc_src2`=01 -> next request address 0x8000_0100, and `pc_plus4`=0x8000_0014 while the instruction is held.
- Jr with `jr_target`=32'h0000_0123 -> next request address 0x120, `align_err` becomes 1 and stays 1 across later fetches.
- Backpressure: `imem_req_ready` low for 4 cycles, response delayed 5 cycles, `instr_ready` low for 3 cycles -> address and instruction are held stable and no duplicate request is issued.
- Reset asserted during WAIT, with the stale response arriving 1 cycle after release -> that response is not captured, the first request after release is to `RESET_PC`, and `instr_valid` stays 0 until the new response arrives.
